// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand register, product register and adder.
// With SEQ_MULT_SIGNED_EN defined, operands are loaded as magnitudes and the fix strobe negates.
module shift_add_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               fix,
    input  logic               mag_en,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     sum;

`ifdef SEQ_MULT_SIGNED_EN
    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is correct as an unsigned value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic en);
        return (en && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction
`endif

    always_comb begin
        sum     = {1'b0, mcand_q} + {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (load) begin
`ifdef SEQ_MULT_SIGNED_EN
            mcand_d = mag(a, mag_en);
            prod_d  = {{WIDTH{1'b0}}, mag(b, mag_en)};
`else
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
`endif
        end else if (step) begin
            if (prod_q[0]) begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
            end else begin
                prod_d = prod_q >> 1;
            end
        end
`ifdef SEQ_MULT_SIGNED_EN
        else if (fix) begin
            prod_d = ~prod_q + (2*WIDTH)'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier top: FSM, iteration counter, sign flag and ready/done handshake.
// Define SEQ_MULT_SIGNED_EN to honour signed_mode (adds the FIX state); otherwise unsigned only.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               ready,
    output logic               done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             load, step;
`ifdef SEQ_MULT_SIGNED_EN
    logic             neg_q, neg_d;
    logic             mode_q, mode_d;
    logic             fix;
`else
    logic             sm_unused;
    assign sm_unused = signed_mode;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d   = neg_q;
        mode_d  = mode_q;
        fix     = 1'b0;
`endif
        // start wins in every state, so a busy unit aborts and restarts silently
        if (start) begin
            load    = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
            ready_d = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            mode_d  = signed_mode;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                        if (mode_q) begin
                            state_d = FIX;
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                        end
`else
                        state_d = IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef SEQ_MULT_SIGNED_EN
                FIX: begin
                    fix     = neg_q;
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
            mode_q  <= mode_d;
`endif
        end
    end

    shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
`ifdef SEQ_MULT_SIGNED_EN
        .fix     (fix),
        .mag_en  (signed_mode),
`endif
        .a       (A),
        .b       (B),
        .product (Product)
    );

    assign ready = ready_q;
    assign done  = done_q;

endmodule
